uart_tx_byte: RTL

Asynchronous serial transmitter driving the board's `UART_TXD` pin, the outgoing counterpart of the `UART_RXD` line. It accepts one byte per valid/ready handshake and shifts it out as an 8N1 frame: start bit, 8 data bits LSB first, stop bit. It sits between on-board producers (calculator value, key events) and the RS-232 transceiver, replacing the constant tie-off of `UART_TXD`.

---
 rtl/omdazz_uart_pkg.sv | 34 +++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/uart_tx_byte.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/omdazz_uart_pkg.sv
// ---------------------------------------------------------------------------
// omdazz_uart_pkg
// Shared definitions for the UART transmit path.
//   - tx_state_t          : transmitter FSM state encoding
//   - DEFAULT_CLK_HZ/BAUD : board clock and default line rate
//   - calc_clks_per_bit() : clocks per bit cell, rounded to nearest
//   - FRAME_CELLS_*       : frame length in bit cells for each build
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity cell).
// ---------------------------------------------------------------------------
package omdazz_uart_pkg;

  localparam int DEFAULT_CLK_HZ = 50_000_000;
  localparam int DEFAULT_BAUD   = 115_200;

  // start + 8 data + stop, optionally + parity
  localparam int FRAME_CELLS_8N1 = 10;
  localparam int FRAME_CELLS_8E1 = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

  // Round to nearest so the bit cell error stays within half a clock.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-cell counter. Counts 0..CLKS_PER_BIT-1 and flags the last clock of
// each cell with tick; wraps to 0 after the tick. clr forces the count to 0.
// Ports:
//   clk  in  : clock
//   rst  in  : asynchronous active-high reset
//   clr  in  : synchronous clear (held while idle, pulsed on acceptance)
//   tick out : high during the final clock of the current bit cell
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick = (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (clr || tick) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 serial transmitter (8E1 with UART_TX_PARITY_EN defined). Accepts one
// byte per valid/ready handshake and shifts it out LSB first.
// Ports:
//   FPGA_CLK  in     : clock
//   RESET_BUT in     : asynchronous active-high reset
//   tx_data   in [8] : byte to send, sampled only on handshake
//   tx_valid  in     : producer has a byte
//   tx_ready  out    : a byte offered now is accepted on the next edge
//   tx_busy   out    : frame in progress (~tx_ready)
//   UART_TXD  out    : serial line, idle high, registered
// Optional feature macro: UART_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module uart_tx_byte
  import omdazz_uart_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD
) (
  input  logic       FPGA_CLK,
  input  logic       RESET_BUT,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       UART_TXD
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);

  tx_state_t  state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [2:0] idx_reg, idx_next;
  logic       txd_reg, txd_next;
`ifdef UART_TX_PARITY_EN
  logic       parity_reg, parity_next;
`endif

  logic baud_clr;
  logic baud_tick;
  logic ready;
  logic accept;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (FPGA_CLK),
    .rst  (RESET_BUT),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  // Ready also in the last clock of the stop cell so a waiting byte is taken
  // on the very edge the stop bit ends: back-to-back frames have no gap.
  assign ready    = (state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_tick);
  assign accept   = tx_valid && ready;
  assign tx_ready = ready;
  assign tx_busy  = ~ready;
  assign UART_TXD = txd_reg;

  // txd_next is the line level for the state being entered, so the line
  // register changes on the same edge as the state register.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    txd_next   = txd_reg;
    baud_clr   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        baud_clr = 1'b1;
        txd_next = 1'b1;
      end
      ST_START: begin
        if (baud_tick) begin
          state_next = ST_DATA;
          idx_next   = 3'd0;
          txd_next   = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_next = {1'b0, shift_reg[7:1]};
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = ST_PARITY;
            txd_next   = parity_reg;
`else
            state_next = ST_STOP;
            txd_next   = 1'b1;
`endif
          end else begin
            txd_next = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          state_next = ST_STOP;
          txd_next   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          state_next = ST_IDLE;
          txd_next   = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        txd_next   = 1'b1;
      end
    endcase

    // Acceptance overrides the above; the start bit goes out on this edge.
    if (accept) begin
      state_next = ST_START;
      shift_next = tx_data;
      idx_next   = 3'd0;
      txd_next   = 1'b0;
      baud_clr   = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_next = ^tx_data;
`endif
    end
  end

  always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
    if (RESET_BUT) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      txd_reg   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      txd_reg   <= txd_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

endmodule
